// File: rtl/beat_scheduler.sv
// beat_scheduler
// Filters beat strobes from the accelerometer beat detector with a hold-off
// window, queues accepted beats in a small FIFO and plays them one at a time
// as fixed-length tones, each followed by a silent gap.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   enable         1 = accept new beats and start queued tones
//   beat_en        beat strobe; only its rising edge is an event
//   beat_intensity intensity qualifying beat_en
//   clear_overflow one-cycle clear of the sticky overflow flag
//   tone_start     one-cycle pulse at the start of each tone
//   tone_on        high while a tone plays
//   tone_sel       intensity of the current/last tone
//   fifo_count     queued events not yet played
//   overflow       sticky: a beat was dropped because the FIFO was full
module beat_scheduler #(
  parameter int unsigned TONE_CYC    = 5000000,
  parameter int unsigned GAP_CYC     = 1000000,
  parameter int unsigned HOLDOFF_CYC = 2500000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        beat_en,
  input  logic [1:0]                  beat_intensity,
  input  logic                        clear_overflow,
  output logic                        tone_start,
  output logic                        tone_on,
  output logic [1:0]                  tone_sel,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Duration counter reloads hold "cycles remaining minus one".
  localparam logic [23:0] TONE_LOAD    = 24'(TONE_CYC - 1);
  localparam logic [23:0] GAP_LOAD     = 24'(GAP_CYC - 1);
  localparam logic [23:0] HOLDOFF_LOAD = 24'(HOLDOFF_CYC);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               beat_prev_q, beat_prev_d;
  logic [23:0]        holdoff_q, holdoff_d;
  logic [23:0]        dur_q, dur_d;
  logic [1:0]         mem_q [FIFO_DEPTH];
  logic [1:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic               overflow_q, overflow_d;
  logic               tone_start_q, tone_start_d;
  logic               tone_on_q, tone_on_d;
  logic [1:0]         tone_sel_q, tone_sel_d;

  logic event_s, accept_s, fifo_full_s, fifo_empty_s, pop_s, push_s, drop_s;

  assign event_s      = beat_en & ~beat_prev_q;
  assign accept_s     = event_s & enable & (holdoff_q == 24'd0);
  assign fifo_full_s  = (fifo_count_q == FULL_CNT);
  assign fifo_empty_s = (fifo_count_q == CNT_W'(0));
  assign pop_s        = (state_q == ST_IDLE) & enable & ~fifo_empty_s;
  // A pop on the same edge frees a slot, so a full FIFO can still take the push.
  assign push_s       = accept_s & (~fifo_full_s | pop_s);
  assign drop_s       = accept_s & fifo_full_s & ~pop_s;

  // Edge register, hold-off window, FIFO storage/pointers and overflow flag.
  always_comb begin
    beat_prev_d = beat_en;

    if (accept_s) begin
      holdoff_d = HOLDOFF_LOAD;
    end else if (holdoff_q != 24'd0) begin
      holdoff_d = holdoff_q - 24'd1;
    end else begin
      holdoff_d = holdoff_q;
    end

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = beat_intensity;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    // A drop wins over a simultaneous clear so no lost beat goes unreported.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Tone sequencer: IDLE pops a beat, PLAY times the tone, GAP times the silence.
  always_comb begin
    state_d      = state_q;
    dur_d        = dur_q;
    tone_start_d = 1'b0;
    tone_on_d    = tone_on_q;
    tone_sel_d   = tone_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d      = ST_PLAY;
          dur_d        = TONE_LOAD;
          tone_start_d = 1'b1;
          tone_on_d    = 1'b1;
          tone_sel_d   = mem_q[rd_ptr_q];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (dur_q == 24'd0) begin
          state_d   = ST_GAP;
          dur_d     = GAP_LOAD;
          tone_on_d = 1'b0;
        end else begin
          dur_d = dur_q - 24'd1;
        end
      end
      ST_GAP: begin
        if (dur_q == 24'd0) begin
          state_d = ST_IDLE;
        end else begin
          dur_d = dur_q - 24'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        dur_d     = 24'd0;
        tone_on_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills any tone and empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_prev_q  <= 1'b0;
      holdoff_q    <= 24'd0;
      dur_q        <= 24'd0;
      mem_q        <= '{default: 2'b00};
      wr_ptr_q     <= PTR_W'(0);
      rd_ptr_q     <= PTR_W'(0);
      fifo_count_q <= CNT_W'(0);
      overflow_q   <= 1'b0;
      tone_start_q <= 1'b0;
      tone_on_q    <= 1'b0;
      tone_sel_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      beat_prev_q  <= beat_prev_d;
      holdoff_q    <= holdoff_d;
      dur_q        <= dur_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      overflow_q   <= overflow_d;
      tone_start_q <= tone_start_d;
      tone_on_q    <= tone_on_d;
      tone_sel_q   <= tone_sel_d;
    end
  end

  assign tone_start = tone_start_q;
  assign tone_on    = tone_on_q;
  assign tone_sel   = tone_sel_q;
  assign fifo_count = fifo_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Testbench for beat_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a timeline-based reference model.
module tb_beat_scheduler;

  localparam int T = 8;
  localparam int G = 4;
  localparam int H = 6;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       beat_en = 1'b0;
  logic [1:0] beat_intensity = 2'b00;
  logic       clear_overflow = 1'b0;
  logic       tone_start;
  logic       tone_on;
  logic [1:0] tone_sel;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int passed = 0;

  // Reference model: a queue of intensities plus the cycle numbers of the
  // last accepted beat and the last tone start.
  int         cyc = 0;
  bit         m_prev;
  bit         acc_valid;
  int         last_acc;
  logic [1:0] mq[$];
  bit         played;
  int         play_start;
  logic [1:0] m_sel;
  bit         m_ovf;
  bit         m_start;
  bit         m_on;

  beat_scheduler #(
    .TONE_CYC   (T),
    .GAP_CYC    (G),
    .HOLDOFF_CYC(H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .beat_en       (beat_en),
    .beat_intensity(beat_intensity),
    .clear_overflow(clear_overflow),
    .tone_start    (tone_start),
    .tone_on       (tone_on),
    .tone_sel      (tone_sel),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev    = 1'b0;
    acc_valid = 1'b0;
    last_acc  = 0;
    mq.delete();
    played    = 1'b0;
    play_start = 0;
    m_sel     = 2'b00;
    m_ovf     = 1'b0;
    m_start   = 1'b0;
    m_on      = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs as sampled.
  task automatic model_step();
    bit ev;
    bit acc;
    bit pop;
    bit drop;
    int pre;
    cyc++;
    ev     = beat_en && !m_prev;
    m_prev = beat_en;
    acc    = ev && enable && (!acc_valid || (cyc - last_acc) > H);
    if (acc) begin
      acc_valid = 1'b1;
      last_acc  = cyc;
    end
    pre = mq.size();
    // A tone occupies T cycles, then G silent cycles, then one idle cycle.
    pop = enable && (pre > 0) && (!played || cyc >= play_start + T + G + 1);
    if (pop) begin
      m_sel      = mq.pop_front();
      played     = 1'b1;
      play_start = cyc;
    end
    drop = 1'b0;
    if (acc) begin
      if (pre < D || pop) mq.push_back(beat_intensity);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    m_start = played && (cyc == play_start);
    m_on    = played && (cyc >= play_start) && (cyc < play_start + T);
  endtask

  task automatic compare_all();
    chk("tone_start", {7'd0, tone_start}, {7'd0, m_start});
    chk("tone_on",    {7'd0, tone_on},    {7'd0, m_on});
    chk("tone_sel",   {6'd0, tone_sel},   {6'd0, m_sel});
    chk("fifo_count", {5'd0, fifo_count}, 8'(mq.size()));
    chk("overflow",   {7'd0, overflow},   {7'd0, m_ovf});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare_all();
  endtask

  // Edge on beat_en for one cycle, next edge possible `gap` cycles later.
  task automatic beat_pulse(input logic [1:0] inten, input int gap);
    beat_en        = 1'b1;
    beat_intensity = inten;
    step();
    beat_en = 1'b0;
    repeat (gap - 1) step();
  endtask

  // Assert reset between edges, check outputs drop at once, hold across an edge.
  task automatic do_async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    compare_all();
    step();
    step();
    #2;
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) step();

    // Single beat of intensity 3.
    beat_pulse(2'b11, 30);

    // Hold-off: edges at E, E+3 (ignored), E+7 (accepted).
    beat_pulse(2'b11, 3);
    beat_pulse(2'b01, 4);
    beat_pulse(2'b10, 40);

    // Overflow: steady beats faster than tones drain.
    for (int i = 0; i < 12; i++) beat_pulse(2'((i % 3) + 1), 7);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    repeat (3) step();
    // Clear coinciding with further drops.
    for (int i = 0; i < 10; i++) begin
      beat_en        = 1'b1;
      beat_intensity = 2'(i);
      clear_overflow = 1'b1;
      step();
      beat_en        = 1'b0;
      clear_overflow = 1'b0;
      repeat (6) step();
    end
    repeat (80) step();
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;

    // Enable gating mid-tone with two beats waiting.
    for (int i = 0; i < 4; i++) beat_pulse(2'((i % 3) + 1), 7);
    beat_pulse(2'b10, 1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) beat_pulse(2'b11, 8);
    enable = 1'b1;
    repeat (50) step();

    // Async reset during a tone with three beats waiting.
    for (int i = 0; i < 6; i++) beat_pulse(2'((i % 3) + 1), 7);
    beat_pulse(2'b01, 1);
    do_async_reset();
    repeat (30) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      beat_en        = ($urandom_range(0, 3) == 0);
      beat_intensity = 2'($urandom_range(0, 3));
      enable         = ($urandom_range(0, 15) != 0);
      clear_overflow = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) do_async_reset();
      else step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
